wowa_result_tx: RTL and testbench
=================================

WOWA_RESULT_TX -- requirements
Module: wowa_result_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit (10 MHz clk gives about 115200 baud); legal range 4..1023.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning result bytes buffered; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  the single clock, 10 MHz nominal.
REQ-004 SHALL have port rst  input  1  synchronous reset, active high.
REQ-005 SHALL have port result_ready  input  1  conversion-done flag from the SAR controller; rising edge marks a new result.
REQ-006 SHALL have port result  input  8  conversion result, valid in the cycle result_ready is first sampled high.
REQ-007 SHALL have port tx_enable  input  1  permits new frames to start.
REQ-008 SHALL have port tx  output  1  8N1 serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-010 SHALL have port fifo_level  output  5  number of buffered bytes, 0..FIFO_DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag: a result was dropped.

Function
REQ-012 SHALL register result_ready into rr_q each cycle; a capture event is result_ready=1 with rr_q=0.
REQ-013 On a capture event with FIFO not full, SHALL write result into the FIFO on that same clock edge.
REQ-014 A level held high on result_ready SHALL produce exactly one capture.
REQ-015 On a capture event with FIFO full and no pop in the same cycle, SHALL drop the byte and set overflow to 1; FIFO contents SHALL be unchanged.
REQ-016 A capture and a pop in the same cycle SHALL both take effect, including when the FIFO is full: the byte is accepted and fifo_level is unchanged.
REQ-017 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; output order SHALL be FIFO order.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 IDLE -> START: occurs when tx_enable=1 and fifo_level>0; pops the head byte into an 8-bit shift register on that edge.
REQ-020 In START, tx SHALL be 0 for CLKS_PER_BIT cycles, then the FSM moves to DATA.
REQ-021 In DATA, SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit counter, then move to STOP.
REQ-022 In STOP, tx SHALL be 1 for CLKS_PER_BIT cycles, then the FSM moves to IDLE.
REQ-023 Back-to-back frames SHALL have exactly one IDLE cycle between the end of STOP and the next START.
REQ-024 tx SHALL be driven from a register (glitch-free); it is 1 in IDLE and STOP.
REQ-025 Latency: tx SHALL fall on the 2nd clock edge after the edge that samples the capture event, given an empty FIFO, IDLE state and tx_enable=1.
REQ-026 Frame length SHALL be 10*CLKS_PER_BIT cycles measured from the falling edge of tx to the end of STOP.
REQ-027 Deasserting tx_enable mid-frame SHALL NOT abort the frame; it only blocks the next IDLE -> START transition.
REQ-028 Captures SHALL continue while tx_enable=0.
REQ-029 The baud counter SHALL reload to 0 on every state or bit transition.

Reset
REQ-030 With rst=1 at a clock edge, the following SHALL take effect on that edge: state=IDLE, tx=1, busy=0, fifo_level=0, overflow=0, pointers=0, rr_q=0, counters=0.
REQ-031 Reset mid-frame SHALL abort the frame; tx SHALL be 1 from the next edge, and buffered bytes SHALL be discarded.
REQ-032 result_ready held high through the deassertion of reset SHALL produce one capture in the first cycle after reset.
REQ-033 overflow SHALL be cleared only by rst.

Verification
REQ-034 Single byte: CLKS_PER_BIT=4, result=0xA5 with a one-cycle result_ready -> tx bits are 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy is high for 40 cycles; fifo_level returns to 0.
REQ-035 Burst: five captures of 0x01..0x05 during one frame with FIFO_DEPTH=4 and the FIFO initially empty -> frames 0x01..0x05 in order; overflow stays 0 because the first pop frees a slot.
REQ-036 Overflow: tx_enable=0, six captures of 0x10..0x15 -> fifo_level=4 and overflow=1; after tx_enable=1, frames 0x10..0x13 only.
REQ-037 Level hold: result_ready held high for 100 cycles with result=0x3C -> exactly one frame of 0x3C.
REQ-038 Reset mid-frame: rst pulsed during DATA bit 3 with 2 bytes queued -> tx=1, busy=0 and fifo_level=0 the next cycle; no further frames.
REQ-039 Simultaneous event: FIFO full and a capture in the same cycle as the IDLE -> START pop -> byte accepted, fifo_level stays 4, overflow=0.

Source files
------------

// File: rtl/wowa_result_tx.sv
// wowa_result_tx: captures SAR conversion results on the rising edge of
// result_ready, buffers them in a small FIFO and sends each one as an 8N1
// UART frame on tx.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high; waits for tx_enable and a buffered byte
// START  | start bit (tx low) for CLKS_PER_BIT cycles
// DATA   | 8 data bits LSB first, CLKS_PER_BIT cycles each
// STOP   | stop bit (tx high) for CLKS_PER_BIT cycles
//
// tx is registered from the current state, so the line lags the state
// register by one cycle. This gives the two-edge capture-to-start-bit
// latency and keeps the line glitch-free.
module wowa_result_tx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       result_ready,
   input  logic [7:0] result,
   input  logic       tx_enable,
   output logic       tx,
   output logic       busy,
   output logic [4:0] fifo_level,
   output logic       overflow
);

   localparam int             PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int             BW        = 10;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [4:0]     DEPTH_L   = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          rr_q, rr_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]    level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_q, bit_d;
   logic [BW-1:0] baud_q, baud_d;
   logic          tx_q, tx_d;

   logic          capture;
   logic          fifo_full;
   logic          pop;
   logic          push;
   logic          baud_done;

   assign capture   = result_ready & ~rr_q;
   assign fifo_full = (level_q == DEPTH_L);
   assign baud_done = (baud_q == BAUD_LAST);
   // A full FIFO still accepts a byte when the head is leaving on the same edge.
   assign push      = capture & (~fifo_full | pop);

   // Edge detector, FIFO pointers, level and sticky overflow.
   always_comb begin
      rr_d     = result_ready;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = result;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (capture && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + 5'd1;
         2'b01:   level_d = level_q - 5'd1;
         default: level_d = level_q;
      endcase
   end

   // Frame sequencer: next state, shift register, bit and baud counters.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      baud_d  = baud_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tx_enable && (level_q != 5'd0)) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               bit_d   = 3'd0;
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_done) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_done) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            baud_d  = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Line level follows the current state; registered one cycle later.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rr_q     <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= 5'd0;
         ovf_q    <= 1'b0;
         shift_q  <= 8'd0;
         bit_q    <= 3'd0;
         baud_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         baud_q   <= baud_d;
         tx_q     <= tx_d;
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign tx         = tx_q;
   assign busy       = (state_q != S_IDLE);
   assign fifo_level = level_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_wowa_result_tx.sv
// Bench for wowa_result_tx: a line monitor decodes frames from tx, and each
// test compares decoded bytes and status outputs against a queue model.
module tb_wowa_result_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FLEN  = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst;
   logic       result_ready;
   logic [7:0] result;
   logic       tx_enable;
   logic       tx;
   logic       busy;
   logic [4:0] fifo_level;
   logic       overflow;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] rx_q[$];
   bit         rx_bad_q[$];
   int         rx_t_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   wowa_result_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .result_ready(result_ready), .result(result),
      .tx_enable(tx_enable), .tx(tx), .busy(busy), .fifo_level(fifo_level),
      .overflow(overflow)
   );

   // Line monitor: after a falling edge, take FLEN samples and require each
   // bit to be constant over its CPB cycles, start=0, stop=1.
   logic       mon_prev = 1'b1;
   int         mon_n = 0;
   int         mon_t = 0;
   logic       mon_s [FLEN];
   logic [7:0] mon_d;
   bit         mon_bad;
   logic       mon_v;

   always @(negedge clk) begin
      if (rst) begin
         mon_n = 0;
      end else if (mon_n == 0) begin
         if (mon_prev && !tx) begin
            mon_s[0] = tx;
            mon_n    = 1;
            mon_t    = cyc;
         end
      end else begin
         mon_s[mon_n] = tx;
         mon_n++;
         if (mon_n == FLEN) begin
            mon_bad = 1'b0;
            mon_d   = 8'd0;
            for (int b = 0; b < 10; b++) begin
               mon_v = mon_s[b*CPB];
               for (int k = 1; k < CPB; k++)
                  if (mon_s[b*CPB+k] !== mon_v) mon_bad = 1'b1;
               if (b == 0 && mon_v !== 1'b0) mon_bad = 1'b1;
               else if (b == 9 && mon_v !== 1'b1) mon_bad = 1'b1;
               else if (b >= 1 && b <= 8) mon_d[b-1] = mon_v;
            end
            rx_q.push_back(mon_d);
            rx_bad_q.push_back(mon_bad);
            rx_t_q.push_back(mon_t);
            mon_n = 0;
         end
      end
      mon_prev = rst ? 1'b1 : tx;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_rx();
      rx_q.delete();
      rx_bad_q.delete();
      rx_t_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; result_ready = 1'b0; tx_enable = 1'b0;
      tick(2);
      rst = 1'b0;
      clr_rx();
   endtask

   task automatic pulse_capture(input logic [7:0] v);
      result = v; result_ready = 1'b1;
      tick(1);
      result_ready = 1'b0;
      tick(1);
   endtask

   task automatic wait_frames(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      ok = (rx_q.size() >= n);
   endtask

   task automatic test_reset();
      rst = 1'b1; result_ready = 1'b0; result = 8'd0; tx_enable = 1'b0;
      tick(2);
      @(negedge clk);
      n_vec++; if (tx !== 1'b1)         begin n_err++; $display("FAIL reset_tx got %b want 1", tx); end
      n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
      rst = 1'b0;
      tick(1);
      for (int j = 0; j < DEPTH + 1; j++) pulse_capture(8'(j));
      n_vec++; if (overflow !== 1'b1)   begin n_err++; $display("FAIL pre_reset_ovf got %b want 1", overflow); end
      tick(20);
      n_vec++; if (overflow !== 1'b1)   begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      rst = 1'b1;
      tick(1);
      n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL reset_clr_ovf got %b want 0", overflow); end
      n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_clr_level got %0d want 0", fifo_level); end
      rst = 1'b0;
      clr_rx();
   endtask

   task automatic test_single();
      int busy_cnt, k;
      bit ok;
      do_reset();
      tx_enable = 1'b1;
      tick(1);
      result = 8'hA5; result_ready = 1'b1;
      @(posedge clk); #1 result_ready = 1'b0;
      @(negedge clk);
      n_vec++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL single_level_e0 got %0d want 1", fifo_level); end
      n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL single_busy_e0 got %b want 0", busy); end
      busy_cnt = 0;
      @(negedge clk);
      if (busy) busy_cnt++;
      n_vec++; if (tx !== 1'b1)         begin n_err++; $display("FAIL single_tx_e1 got %b want 1", tx); end
      n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL single_level_e1 got %0d want 0", fifo_level); end
      @(negedge clk);
      if (busy) busy_cnt++;
      n_vec++; if (tx !== 1'b0)         begin n_err++; $display("FAIL single_latency_tx_e2 got %b want 0", tx); end
      k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         k++;
      end
      n_vec++; if (busy_cnt != FLEN)    begin n_err++; $display("FAIL single_busy_len got %0d want %0d", busy_cnt, FLEN); end
      wait_frames(1, 20, ok);
      n_vec++; if (!ok)                 begin n_err++; $display("FAIL single_timeout got %0d frames want 1", rx_q.size()); end
      n_vec++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || rx_bad_q[0])
         begin n_err++; $display("FAIL single_frame got %h bad=%0b n=%0d want a5", rx_q[0], rx_bad_q[0], rx_q.size()); end
      n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL single_level_end got %0d want 0", fifo_level); end
   endtask

   task automatic test_reset_hold();
      bit ok;
      rst = 1'b1; tx_enable = 1'b0; result = 8'h5A; result_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      clr_rx();
      tick(1);
      n_vec++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL rsthold_level got %0d want 1", fifo_level); end
      tick(5);
      n_vec++; if (fifo_level !== 5'd1) begin n_err++; $display("FAIL rsthold_once got %0d want 1", fifo_level); end
      result_ready = 1'b0;
      tx_enable = 1'b1;
      wait_frames(1, 100, ok);
      n_vec++; if (!ok || rx_q[0] !== 8'h5A || rx_bad_q[0])
         begin n_err++; $display("FAIL rsthold_frame got %h n=%0d want 5a", rx_q[0], rx_q.size()); end
      tick(10);
   endtask

   task automatic test_burst();
      logic [7:0] exp_q[$];
      bit ok;
      do_reset();
      tx_enable = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         pulse_capture(8'(j));
         exp_q.push_back(8'(j));
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_ovf_early got %b want 0", overflow); end
      wait_frames(5, 5 * (FLEN + 1) + 60, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL burst_timeout got %0d frames want 5", rx_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_vec++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i] || rx_bad_q[i])
            begin n_err++; $display("FAIL burst_frame[%0d] got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      for (int i = 1; i < rx_t_q.size(); i++) begin
         n_vec++;
         if (rx_t_q[i] - rx_t_q[i-1] != FLEN + 1)
            begin n_err++; $display("FAIL burst_gap[%0d] got %0d want %0d", i, rx_t_q[i] - rx_t_q[i-1], FLEN + 1); end
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_ovf got %b want 0", overflow); end
      tick(5);
   endtask

   task automatic test_overflow();
      logic [7:0] exp_q[$];
      logic [7:0] v;
      bit ovf, ok;
      int n;
      for (int it = 0; it < 3; it++) begin
         do_reset();
         exp_q.delete();
         ovf = 1'b0;
         n = (it == 0) ? 6 : int'($urandom_range(1, 8));
         for (int j = 0; j < n; j++) begin
            v = (it == 0) ? 8'(8'h10 + j) : 8'($urandom);
            pulse_capture(v);
            if (exp_q.size() < DEPTH) exp_q.push_back(v);
            else ovf = 1'b1;
         end
         n_vec++; if (fifo_level !== 5'(exp_q.size()))
            begin n_err++; $display("FAIL ovf_level[%0d] got %0d want %0d", it, fifo_level, exp_q.size()); end
         n_vec++; if (overflow !== ovf)
            begin n_err++; $display("FAIL ovf_flag[%0d] got %b want %b", it, overflow, ovf); end
         tx_enable = 1'b1;
         wait_frames(exp_q.size(), DEPTH * (FLEN + 1) + 60, ok);
         tick(2 * FLEN);
         n_vec++; if (rx_q.size() != exp_q.size())
            begin n_err++; $display("FAIL ovf_count[%0d] got %0d want %0d", it, rx_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i] || rx_bad_q[i])
               begin n_err++; $display("FAIL ovf_frame[%0d][%0d] got %h want %h", it, i, rx_q[i], exp_q[i]); end
         end
         n_vec++; if (overflow !== ovf)
            begin n_err++; $display("FAIL ovf_hold[%0d] got %b want %b", it, overflow, ovf); end
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp_q[$];
      logic [7:0] v;
      bit ok;
      do_reset();
      for (int j = 0; j < DEPTH; j++) begin
         v = 8'($urandom);
         pulse_capture(v);
         exp_q.push_back(v);
      end
      n_vec++; if (fifo_level !== 5'(DEPTH)) begin n_err++; $display("FAIL simul_full got %0d want %0d", fifo_level, DEPTH); end
      v = 8'($urandom);
      exp_q.push_back(v);
      result = v; result_ready = 1'b1; tx_enable = 1'b1;
      tick(1);
      result_ready = 1'b0;
      n_vec++; if (fifo_level !== 5'(DEPTH)) begin n_err++; $display("FAIL simul_level got %0d want %0d", fifo_level, DEPTH); end
      n_vec++; if (overflow !== 1'b0)        begin n_err++; $display("FAIL simul_ovf got %b want 0", overflow); end
      n_vec++; if (busy !== 1'b1)            begin n_err++; $display("FAIL simul_busy got %b want 1", busy); end
      wait_frames(5, 5 * (FLEN + 1) + 60, ok);
      for (int i = 0; i < exp_q.size(); i++) begin
         n_vec++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i] || rx_bad_q[i])
            begin n_err++; $display("FAIL simul_frame[%0d] got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      tick(5);
   endtask

   task automatic test_level_hold();
      bit ok;
      do_reset();
      tx_enable = 1'b1;
      result = 8'h3C; result_ready = 1'b1;
      tick(1);
      result = 8'hC3;
      tick(99);
      result_ready = 1'b0;
      wait_frames(1, 100, ok);
      tick(3 * FLEN);
      n_vec++; if (rx_q.size() != 1) begin n_err++; $display("FAIL hold_count got %0d want 1", rx_q.size()); end
      n_vec++; if (rx_q[0] !== 8'h3C || rx_bad_q[0]) begin n_err++; $display("FAIL hold_frame got %h want 3c", rx_q[0]); end
   endtask

   task automatic test_enable_gate();
      logic [7:0] b0, b1;
      bit ok;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      do_reset();
      tx_enable = 1'b1;
      pulse_capture(b0);
      tick(3);
      tx_enable = 1'b0;
      pulse_capture(b1);
      wait_frames(1, FLEN + 40, ok);
      tick(2 * FLEN);
      n_vec++; if (rx_q.size() != 1 || rx_q[0] !== b0 || rx_bad_q[0])
         begin n_err++; $display("FAIL gate_first got %h n=%0d want %h", rx_q[0], rx_q.size(), b0); end
      n_vec++; if (fifo_level !== 5'd1 || busy !== 1'b0)
         begin n_err++; $display("FAIL gate_held got level=%0d busy=%b want 1/0", fifo_level, busy); end
      tx_enable = 1'b1;
      wait_frames(2, FLEN + 40, ok);
      n_vec++; if (!ok || rx_q[1] !== b1 || rx_bad_q[1])
         begin n_err++; $display("FAIL gate_second got %h want %h", rx_q[1], b1); end
      tick(5);
   endtask

   task automatic test_random_stream();
      logic [7:0] exp_q[$];
      logic [7:0] v;
      bit ok;
      do_reset();
      tx_enable = 1'b1;
      for (int j = 0; j < 12; j++) begin
         v = 8'($urandom);
         pulse_capture(v);
         exp_q.push_back(v);
         tick(int'($urandom_range(35, 70)));
      end
      wait_frames(12, 12 * (FLEN + 1) + 100, ok);
      n_vec++; if (rx_q.size() != 12) begin n_err++; $display("FAIL stream_count got %0d want 12", rx_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_vec++;
         if (i >= rx_q.size() || rx_q[i] !== exp_q[i] || rx_bad_q[i])
            begin n_err++; $display("FAIL stream_frame[%0d] got %h want %h", i, rx_q[i], exp_q[i]); end
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL stream_ovf got %b want 0", overflow); end
   endtask

   task automatic test_reset_mid_frame();
      int k;
      do_reset();
      for (int j = 0; j < 3; j++) pulse_capture(8'($urandom));
      tx_enable = 1'b1;
      k = 0;
      while (!busy && k < 10) begin tick(1); k++; end
      n_vec++; if (fifo_level !== 5'd2) begin n_err++; $display("FAIL midrst_queued got %0d want 2", fifo_level); end
      tick(17);
      rst = 1'b1;
      tick(1);
      n_vec++; if (tx !== 1'b1)         begin n_err++; $display("FAIL midrst_tx got %b want 1", tx); end
      n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
      n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL midrst_level got %0d want 0", fifo_level); end
      rst = 1'b0;
      tick(4 * FLEN);
      n_vec++; if (rx_q.size() != 0)    begin n_err++; $display("FAIL midrst_frames got %0d want 0", rx_q.size()); end
      n_vec++; if (tx !== 1'b1 || busy !== 1'b0)
         begin n_err++; $display("FAIL midrst_idle got tx=%b busy=%b want 1/0", tx, busy); end
   endtask

   initial begin
      rst = 1'b1; result_ready = 1'b0; result = 8'd0; tx_enable = 1'b0;
      test_reset();
      test_single();
      test_reset_hold();
      test_burst();
      test_overflow();
      test_simultaneous();
      test_level_hold();
      test_enable_gate();
      test_random_stream();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
